dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the pipeline's mm_* load/store port.
//   Accepts one request at a time, holds it for LATENCY cycles, commits byte-masked
//   writes into an internal 64-bit-wide SRAM, and returns aligned doublewords with a
//   one-cycle rdata_valid pulse.
//   Sits between the memory-access stage and the simulated data store.
//   Provides the wait-state behaviour that stage relies on to stall.
// PARAMETERS
//   DEPTH_WORDS  4096            number of 64-bit words; power of 2, >= 2
//   BASE_ADDR    64'h8000_0000   byte address of word 0; aligned to DEPTH_WORDS*8
//   LATENCY      2               cycles from accepting edge to rdata_valid; 1..15
// PORTS
//   clk          in   1   clock, rising edge
//   rstn         in   1   reset, asynchronous, active-low
//   mm_addr      in   64  byte address; [2:0] = byte offset within doubleword
//   mm_wdata     in   64  store data, LSB-aligned (byte 0 = mm_wdata[7:0])
//   mm_wlen      in   4   store size in bytes: 1, 2, 4 or 8
//   mm_wen       in   1   store request, level, held until rdata_valid
//   mm_ren       in   1   load request, level, held until rdata_valid
//   mm_rdata     out  64  aligned doubleword at {mm_addr[63:3],3'b0}
//   rdata_valid  out  1   one-cycle response pulse: load data valid / store done
//   mm_busy      out  1   request in flight; initiator must hold its request
//   mm_err       out  1   pulses with rdata_valid on a bad access
// BEHAVIOUR
//   Reset (async, rstn=0):
//     - state=IDLE; mm_rdata=0, rdata_valid=0, mm_busy=0, mm_err=0.
//     - SRAM contents are not reset.
//     - Reset mid-request drops the request; no write is committed.
//   FSM IDLE -> WAIT -> RESP -> IDLE.
//     - IDLE: if mm_wen|mm_ren at an edge, latch addr/wdata/wlen/op.
//       cnt<=LATENCY-1; go to WAIT, or straight to RESP if LATENCY==1.
//     - WAIT: cnt decrements each edge; at cnt==1 go to RESP.
//     - RESP: rdata_valid=1 and mm_err as computed; next edge returns to IDLE.
//   mm_busy=1 in WAIT and RESP.
//   A request still asserted in IDLE after RESP is a new request. The initiator
//   drops or changes its request on the edge where it samples rdata_valid.
//   Data path:
//     - SRAM access happens on the edge entering RESP; mm_rdata is registered
//       on that edge.
//     - mm_rdata holds its value until the next response.
//   Index = (addr-BASE_ADDR)>>3. Out of range when addr<BASE_ADDR or index>=DEPTH_WORDS.
//   Write byte mask = ((1<<wlen)-1) << addr[2:0], truncated to 8 bits.
//   Write data = latched wdata << (8*addr[2:0]).
//   Misaligned when addr[2:0] is not a multiple of wlen, or wlen is not in {1,2,4,8}.
//   mm_err=1 for: out of range (read or write), or misaligned store.
//     - On error: no write is committed; mm_rdata=0; rdata_valid still pulses.
//   Loads ignore alignment; the initiator extracts bytes from the doubleword.
//   mm_wen & mm_ren together: store wins, read is ignored. Response rdata is the
//   word after the write (0 on error).
//   Requests are accepted only in IDLE. Request input changes in WAIT/RESP are ignored.
// TESTING
//   1. Reset: rstn=0 mid-WAIT (async) -> rdata_valid=0, mm_busy=0 same cycle.
//      Target word is unchanged on a later read.
//   2. Latency: LATENCY=2; ren @0x8000_0010, accept edge N ->
//      mm_busy=1 N..N+1, rdata_valid=1 only in the cycle after edge N+1.
//   3. Byte mask: sd 0x1122334455667788 @0x8000_0008; then sb 0xAA @0x8000_000B
//      -> ld 0x8000_0008 returns 0x11223344AA667788.
//   4. Halfword: sh 0xBEEF @0x8000_000E -> upper 16 bits of the word = 0xBEEF,
//      others unchanged.
//   5. Errors: sw @0x8000_0002 -> mm_err=1, no write. ld @0x7FFF_FFF8 -> mm_err=1,
//      mm_rdata=0. ld @BASE+DEPTH_WORDS*8 -> mm_err=1.
//   6. Back-to-back: ren held across two addresses, changed on each rdata_valid
//      -> two responses spaced LATENCY+1 cycles apart with correct data.
//      wen&ren together -> single store response.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store port between the memory-access stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
    logic [63:0] mm_addr;
    logic [63:0] mm_wdata;
    logic [3:0]  mm_wlen;
    logic        mm_wen;
    logic        mm_ren;
    logic [63:0] mm_rdata;
    logic        rdata_valid;
    logic        mm_busy;
    logic        mm_err;

    modport master (
        output mm_addr, mm_wdata, mm_wlen, mm_wen, mm_ren,
        input  mm_rdata, rdata_valid, mm_busy, mm_err
    );

    modport slave (
        input  mm_addr, mm_wdata, mm_wlen, mm_wen, mm_ren,
        output mm_rdata, rdata_valid, mm_busy, mm_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, LATENCY wait states, byte-masked
// stores into a 64-bit-wide internal SRAM and aligned doubleword load returns.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rstn,
    dmem_responder_if.slave mm
);
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [63:0] DEPTH_64 = 64'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [7:0] byte_mask(input logic [3:0] wlen, input logic [2:0] ofs);
        logic [7:0] len_mask;
        case (wlen)
            4'd1:    len_mask = 8'h01;
            4'd2:    len_mask = 8'h03;
            4'd4:    len_mask = 8'h0F;
            4'd8:    len_mask = 8'hFF;
            default: len_mask = 8'h00;
        endcase
        return len_mask << ofs;
    endfunction

    function automatic logic misaligned(input logic [3:0] wlen, input logic [2:0] ofs);
        logic bad;
        case (wlen)
            4'd1:    bad = 1'b0;
            4'd2:    bad = ofs[0];
            4'd4:    bad = |ofs[1:0];
            4'd8:    bad = |ofs;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [63:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wlen;
    logic        lat_wr;

    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_wlen;
    logic        req_wr;

    logic        accept, enter_resp, commit;
    logic [63:0] off;
    logic [IDX_W-1:0] idx;
    logic        oob, err;
    logic [7:0]  bmask;
    logic [63:0] bit_mask, wdata_sh, old_word, new_word;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [63:0] mem [DEPTH_WORDS];

    assign accept = (state == IDLE) && (mm.mm_wen || mm.mm_ren);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    // With LATENCY==1 the access happens on the accepting edge, so it uses the live request.
    always_comb begin
        req_addr  = lat_addr;
        req_wdata = lat_wdata;
        req_wlen  = lat_wlen;
        req_wr    = lat_wr;
        if (state == IDLE) begin
            req_addr  = mm.mm_addr;
            req_wdata = mm.mm_wdata;
            req_wlen  = mm.mm_wlen;
            req_wr    = mm.mm_wen;
        end
    end

    assign off      = req_addr - BASE_ADDR;
    assign idx      = off[IDX_W+2:3];
    assign oob      = (req_addr < BASE_ADDR) || ((off >> 3) >= DEPTH_64);
    assign err      = oob || (req_wr && misaligned(req_wlen, req_addr[2:0]));
    assign bmask    = byte_mask(req_wlen, req_addr[2:0]);
    assign wdata_sh = req_wdata << {req_addr[2:0], 3'b000};

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{bmask[i]}};
    end

    assign old_word = mem[idx];
    assign new_word = (old_word & ~bit_mask) | (wdata_sh & bit_mask);
    assign commit   = enter_resp && req_wr && !err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= CNT_INIT;
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (enter_resp) begin
                rdata_q <= err ? 64'd0 : (req_wr ? new_word : old_word);
                err_q   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= mm.mm_addr;
            lat_wdata <= mm.mm_wdata;
            lat_wlen  <= mm.mm_wlen;
            lat_wr    <= mm.mm_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= new_word;
    end

    assign mm.mm_rdata    = rdata_q;
    assign mm.rdata_valid = (state == RESP);
    assign mm.mm_err      = (state == RESP) && err_q;
    assign mm.mm_busy     = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: table of load/store transactions plus
// hand-written latency, reset, back-to-back and combined-request sequences.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk (clk),
        .rstn(rstn),
        .mm  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wlen;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [3:0] wlen);
        bus.mm_wen   = wr;
        bus.mm_ren   = rd;
        bus.mm_addr  = addr;
        bus.mm_wdata = wdata;
        bus.mm_wlen  = wlen;
    endtask

    // Entered #1 after a rising edge; returns #1 after the edge that samples rdata_valid.
    task automatic do_req(input logic wr, input logic rd, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [3:0] wlen,
                          output logic [63:0] rdata, output logic err, output int lat);
        logic got;
        got   = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        drive(wr, rd, addr, wdata, wlen);
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.rdata_valid) begin
                got   = 1'b1;
                rdata = bus.mm_rdata;
                err   = bus.mm_err;
            end
        end
        @(posedge clk); #1;
        bus.mm_wen = 1'b0;
        bus.mm_ren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          nr, k, cnt_v;
        int          tv [2];
        logic [63:0] dv [2];

        rstn = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);

        vecs[0]  = '{1'b1, 1'b0, 64'h8000_0008, 64'h1122334455667788, 4'd8, 64'h1122334455667788, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 64'h8000_000B, 64'h00000000000000AA, 4'd1, 64'h11223344AA667788, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 64'h8000_0008, 64'h0,                4'd8, 64'h11223344AA667788, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 64'h8000_000E, 64'h000000000000BEEF, 4'd2, 64'hBEEF3344AA667788, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 64'h8000_000C, 64'h0,                4'd0, 64'hBEEF3344AA667788, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 64'h8000_0000, 64'hCAFEF00D12345678, 4'd8, 64'hCAFEF00D12345678, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 64'h8000_0002, 64'h00000000DEADBEEF, 4'd4, 64'h0,                1'b1};
        vecs[7]  = '{1'b0, 1'b1, 64'h8000_0000, 64'h0,                4'd8, 64'hCAFEF00D12345678, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 64'h8000_0004, 64'h00000000DEADBEEF, 4'd4, 64'hDEADBEEF12345678, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 64'h8000_0007, 64'h0000000000000099, 4'd1, 64'h99ADBEEF12345678, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 64'h8000_0001, 64'hFFFFFFFFFFFFFF42, 4'd1, 64'h99ADBEEF12344278, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 64'h8000_0001, 64'h0000000000001234, 4'd2, 64'h0,                1'b1};
        vecs[12] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0000000000000001, 4'd3, 64'h0,                1'b1};
        vecs[13] = '{1'b0, 1'b1, 64'h8000_0000, 64'h0,                4'd8, 64'h99ADBEEF12344278, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 64'h7FFF_FFF8, 64'h0,                4'd8, 64'h0,                1'b1};
        vecs[15] = '{1'b0, 1'b1, 64'h8000_8000, 64'h0,                4'd8, 64'h0,                1'b1};
        vecs[16] = '{1'b1, 1'b0, 64'h8000_7FF8, 64'h5555AAAA5555AAAA, 4'd8, 64'h5555AAAA5555AAAA, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 64'h8000_7FFC, 64'h0,                4'd8, 64'h5555AAAA5555AAAA, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 64'h8000_8000, 64'h0000000000000001, 4'd8, 64'h0,                1'b1};
        vecs[19] = '{1'b1, 1'b0, 64'h8000_0010, 64'h0123456789ABCDEF, 4'd8, 64'h0123456789ABCDEF, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 64'h8000_0013, 64'h0,                4'd8, 64'h0123456789ABCDEF, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 64'h1_8000_0000, 64'h0,              4'd8, 64'h0,                1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset rdata", bus.mm_rdata, 64'd0);
        check("reset valid", 64'(bus.rdata_valid), 64'd0);
        check("reset busy", 64'(bus.mm_busy), 64'd0);
        check("reset err", 64'(bus.mm_err), 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wlen, rd, er, lat);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i), 64'(lat), 64'(LAT));
        end

        // Latency profile of a single load
        drive(1'b0, 1'b1, 64'h8000_0010, 64'd0, 4'd8);
        @(posedge clk); #1;
        check("lat N busy", 64'(bus.mm_busy), 64'd1);
        check("lat N valid", 64'(bus.rdata_valid), 64'd0);
        @(posedge clk); #1;
        check("lat N+1 busy", 64'(bus.mm_busy), 64'd1);
        check("lat N+1 valid", 64'(bus.rdata_valid), 64'd1);
        check("lat N+1 rdata", bus.mm_rdata, 64'h0123456789ABCDEF);
        bus.mm_ren = 1'b0;
        @(posedge clk); #1;
        check("lat N+2 busy", 64'(bus.mm_busy), 64'd0);
        check("lat N+2 valid", 64'(bus.rdata_valid), 64'd0);
        check("lat rdata hold", bus.mm_rdata, 64'h0123456789ABCDEF);

        // Asynchronous reset in the middle of a store
        drive(1'b1, 1'b0, 64'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 4'd8);
        @(posedge clk); #1;
        check("rst accept busy", 64'(bus.mm_busy), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst async valid", 64'(bus.rdata_valid), 64'd0);
        check("rst async busy", 64'(bus.mm_busy), 64'd0);
        check("rst async rdata", bus.mm_rdata, 64'd0);
        bus.mm_wen = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        do_req(1'b0, 1'b1, 64'h8000_0010, 64'd0, 4'd8, rd, er, lat);
        check("rst no write", rd, 64'h0123456789ABCDEF);
        check("rst no write err", 64'(er), 64'd0);

        // Back-to-back loads with ren held, address changed on each response
        tv[0] = 0; tv[1] = 0; dv[0] = '0; dv[1] = '0;
        nr = 0; k = 0;
        drive(1'b0, 1'b1, 64'h8000_0008, 64'd0, 4'd8);
        while (nr < 2 && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (bus.rdata_valid) begin
                tv[nr] = k;
                dv[nr] = bus.mm_rdata;
                nr++;
                @(posedge clk); #1;
                k++;
                if (nr == 1) bus.mm_addr = 64'h8000_0000;
                else bus.mm_ren = 1'b0;
            end
        end
        bus.mm_ren = 1'b0;
        check("b2b count", 64'(nr), 64'd2);
        check("b2b spacing", 64'(tv[1] - tv[0]), 64'(LAT + 1));
        check("b2b data0", dv[0], 64'hBEEF3344AA667788);
        check("b2b data1", dv[1], 64'h99ADBEEF12344278);

        // Store and load together: store wins, exactly one response
        do_req(1'b1, 1'b1, 64'h8000_0018, 64'hA5A55A5A0F0FF0F0, 4'd8, rd, er, lat);
        check("wr+rd rdata", rd, 64'hA5A55A5A0F0FF0F0);
        check("wr+rd err", 64'(er), 64'd0);
        cnt_v = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.rdata_valid) cnt_v++;
        end
        check("wr+rd single resp", 64'(cnt_v), 64'd0);
        do_req(1'b0, 1'b1, 64'h8000_0018, 64'd0, 4'd8, rd, er, lat);
        check("wr+rd readback", rd, 64'hA5A55A5A0F0FF0F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
